mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the number of serve-state cycles without a RAM response before the access is aborted.
REQ-002 The block SHALL have parameter WORD_W, default 32, meaning the data and address width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; all state updates on its rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 iREN  in  1  icache read request.
REQ-007 iaddr  in  WORD_W  icache word address.
REQ-008 iwait  out  1  icache must hold its request.
REQ-009 iload  out  WORD_W  icache read data.
REQ-010 dREN, dWEN  in  1 each  dcache read and write requests.
REQ-011 daddr, dstore  in  WORD_W each  dcache address and write data.
REQ-012 dwait  out  1  dcache must hold its request.
REQ-013 dload  out  WORD_W  dcache read data.
REQ-014 ramREN, ramWEN  out  1 each  RAM read and write strobes.
REQ-015 ramaddr, ramstore  out  WORD_W each  RAM address and write data.
REQ-016 ramload  in  WORD_W  RAM read data.
REQ-017 ramstate  in  2  RAM status, type ramstate_t: FREE, BUSY, ACCESS or ERROR.
REQ-018 err  out  1  sticky error flag, set by a RAM ERROR or a timeout.

Function
REQ-019 The FSM SHALL have three states: IDLE, ISERVE and DSERVE.
REQ-020 In IDLE, all RAM strobes SHALL be 0, and iwait/dwait SHALL equal their requester's request (iREN, or dREN|dWEN).
REQ-021 In IDLE with a dcache request pending, the FSM SHALL go to DSERVE next cycle; otherwise, with iREN pending, to ISERVE; otherwise it stays in IDLE.
REQ-022 In a serve state, ram outputs SHALL be driven combinationally from the granted requester; the non-granted requester's RAM inputs SHALL be ignored.
REQ-023 When dREN and dWEN are both 1, ramWEN=1 and ramREN=0 (write wins).
REQ-024 Completion SHALL occur when ramstate==ACCESS in a serve state; in that cycle the granted wait=0 and the load output passes ramload combinationally.
REQ-025 After completion, the FSM SHALL return to IDLE the next cycle; minimum latency is 2 cycles from request to wait=0.
REQ-026 A non-granted requester SHALL see wait=1 while its request is asserted.
REQ-027 iload and dload SHALL be 0 except during their own completion cycle.
REQ-028 If the granted requester drops its request before completion, the FSM SHALL go to IDLE next cycle with RAM strobes 0 in that cycle.
REQ-029 ramstate==ERROR in a serve state SHALL be treated as completion, with err set the next cycle.
REQ-030 A timeout counter SHALL clear on entering a serve state and increment each serve cycle without ACCESS or ERROR.
REQ-031 When the timeout count reaches TIMEOUT, the block SHALL set err, drive wait=0 and load=0 for one cycle, and return to IDLE.
REQ-032 err SHALL stay 1 until reset.

Reset
REQ-033 On RST, the FSM SHALL go to IDLE, the counter to 0, err to 0 and last_grant to I.
REQ-034 All ram and load outputs SHALL be 0 during and after reset.
REQ-035 iwait/dwait SHALL follow REQ-020 while RST is high.
REQ-036 RST asserted mid-access SHALL abort the access with no completion cycle.

Configuration
REQ-037 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-038 When ARB_ROUND_ROBIN_EN is defined and both caches request in IDLE, the grant SHALL go to the cache other than last_grant; last_grant updates on each grant.
REQ-039 When ARB_ROUND_ROBIN_EN is undefined, dcache SHALL always win, and no last_grant register SHALL exist.

Structure
REQ-040 ramstate_t and arb_state_t (IDLE, ISERVE, DSERVE) SHALL reside in cpu_types_pkg.
REQ-041 The timeout counter SHALL be sub-module arb_timeout_counter, with ports clear, enable and expired, parameterised by TIMEOUT.

Verification
REQ-042 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> iwait=0 on cycle 3, iload=0xDEADBEEF, FSM in IDLE on cycle 4.
REQ-043 iREN and dWEN asserted the same cycle, daddr=0x80, dstore=0x1234 -> DSERVE first with ramWEN=1, ramstore=0x1234, iwait=1 throughout; ISERVE follows.
REQ-044 Round-robin build: three back-to-back cycles with both caches requesting -> grants in order D, I, D.
REQ-045 ramstate held BUSY with TIMEOUT=15 -> dwait=0 after 15 serve cycles, err=1 and stays 1, FSM in IDLE.
REQ-046 RST pulsed in DSERVE -> next cycle all ram outputs 0, err=0, FSM IDLE; dREN dropped mid-service -> IDLE next cycle with ramREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter FSM states and grant owner.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISERVE = 2'd1,
    DSERVE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // ERROR ends an access just like ACCESS does; only the sticky flag differs.
  function automatic logic is_response(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts serve cycles without a RAM response; expired flags the cycle in which
// the count reaches TIMEOUT.
module arb_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The current unanswered cycle is the TIMEOUT-th one, so the count never wraps.
  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache reads and dcache reads/writes onto one RAM port, with timeout and sticky error.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the dcache always wins.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              err
);

  arb_state_t state_q, state_d;
  logic       err_q, err_d;
  logic       dreq;
  logic       granted_req;
  logic       resp;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       tmo_expired;
  logic       pick_d;

  assign dreq        = dREN | dWEN;
  assign resp        = is_response(ramstate);
  assign granted_req = (state_q == ISERVE) ? iREN :
                       (state_q == DSERVE) ? dreq : 1'b0;
  assign cnt_clear   = (state_q == IDLE);
  assign cnt_enable  = !RST && granted_req && !resp;

  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (CLK),
    .rst    (RST),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(tmo_expired)
  );

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant_q, last_grant_d;

  // On a tie the grant goes to whichever cache did not win last time.
  assign pick_d = dreq && (!iREN || (last_grant_q == GRANT_I));

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && (dreq || iREN)) begin
      last_grant_d = pick_d ? GRANT_D : GRANT_I;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_q <= GRANT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign pick_d = dreq;
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    iwait    = iREN;
    dwait    = dreq;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    // Under reset the block looks idle regardless of state, so no access can complete.
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_d = DSERVE;
          end else if (iREN) begin
            state_d = ISERVE;
          end
        end
        ISERVE: begin
          if (!iREN) begin
            state_d = IDLE;
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (resp) begin
              iwait   = 1'b0;
              iload   = ramload;
              err_d   = err_q | (ramstate == ERROR);
              state_d = IDLE;
            end else if (tmo_expired) begin
              iwait   = 1'b0;
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        DSERVE: begin
          if (!dreq) begin
            state_d = IDLE;
          end else begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (resp) begin
              dwait   = 1'b0;
              dload   = ramload;
              err_d   = err_q | (ramstate == ERROR);
              state_d = IDLE;
            end else if (tmo_expired) begin
              dwait   = 1'b0;
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int W       = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  ramstate_t    ramstate;
  logic         iwait, dwait, ramREN, ramWEN, err;
  logic [W-1:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial forever #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 icache, 2 dcache), unanswered serve cycles, sticky error.
  int           m_owner = 0;
  int           m_busy  = 0;
  int           m_last  = 1;
  bit           m_err   = 1'b0;
  bit           m_known = 1'b0;
  logic         m_dreq, m_req, m_resp, m_tmo;
  logic         e_iwait, e_dwait, e_ren, e_wen;
  logic [W-1:0] e_iload, e_dload, e_addr, e_store;

  always @(negedge CLK) begin
    m_dreq  = dREN | dWEN;
    e_iwait = iREN;
    e_dwait = m_dreq;
    e_iload = '0;
    e_dload = '0;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_addr  = '0;
    e_store = '0;
    m_req   = 1'b0;
    m_resp  = 1'b0;
    m_tmo   = 1'b0;
    if (!RST && m_owner != 0) begin
      m_req  = (m_owner == 1) ? iREN : m_dreq;
      m_resp = (ramstate == ACCESS) || (ramstate == ERROR);
      m_tmo  = !m_resp && (m_busy + 1 >= TIMEOUT);
      if (m_req) begin
        if (m_owner == 1) begin
          e_ren  = 1'b1;
          e_addr = iaddr;
          if (m_resp || m_tmo) begin
            e_iwait = 1'b0;
            e_iload = m_resp ? ramload : '0;
          end
        end else begin
          e_wen   = dWEN;
          e_ren   = dREN && !dWEN;
          e_addr  = daddr;
          e_store = dstore;
          if (m_resp || m_tmo) begin
            e_dwait = 1'b0;
            e_dload = m_resp ? ramload : '0;
          end
        end
      end
    end
    if (RST || m_known) begin
      chk1("iwait", iwait, e_iwait);
      chk1("dwait", dwait, e_dwait);
      chk("iload", iload, e_iload);
      chk("dload", dload, e_dload);
      chk1("ramREN", ramREN, e_ren);
      chk1("ramWEN", ramWEN, e_wen);
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);
    end
    if (m_known && !RST) chk1("err", err, m_err);
    // Advance the model to the state after the coming rising edge.
    if (RST) begin
      m_owner = 0;
      m_busy  = 0;
      m_err   = 1'b0;
      m_last  = 1;
      m_known = 1'b1;
    end else if (m_known) begin
      if (m_owner == 0) begin
        if (m_dreq && iREN) m_owner = RR ? ((m_last == 1) ? 2 : 1) : 2;
        else if (m_dreq)    m_owner = 2;
        else if (iREN)      m_owner = 1;
        if (m_owner != 0) m_last = m_owner;
        m_busy = 0;
      end else if (!m_req || m_resp || m_tmo) begin
        if (m_req && (ramstate == ERROR || m_tmo)) m_err = 1'b1;
        m_owner = 0;
      end else begin
        m_busy++;
      end
    end
  end

  // Apply one cycle of inputs just after the edge, then wait until after the model's check.
  task automatic drive(input int r, input int ir, input int dr, input int dw, input ramstate_t rs);
    @(posedge CLK);
    #1;
    RST      = (r != 0);
    iREN     = (ir != 0);
    dREN     = (dr != 0);
    dWEN     = (dw != 0);
    ramstate = rs;
    #5;
  endtask

  int rv;

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = 32'hCAFE_0001; ramstate = FREE;

    // Reset with requests present: waits follow requests, RAM and loads stay 0.
    drive(1, 1, 0, 0, BUSY);
    chk1("rst_iwait", iwait, 1'b1);
    chk1("rst_ramREN", ramREN, 1'b0);
    drive(1, 0, 1, 1, ACCESS);
    chk1("rst_dwait", dwait, 1'b1);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_dload", dload, '0);
    drive(0, 0, 0, 0, FREE);
    chk1("rst_err", err, 1'b0);

    // Icache read: two BUSY cycles, then ACCESS.
    iaddr = 32'h40; ramload = 32'hDEAD_BEEF;
    drive(0, 1, 0, 0, BUSY);
    chk1("i_c1_iwait", iwait, 1'b1);
    chk1("i_c1_ramREN", ramREN, 1'b0);
    drive(0, 1, 0, 0, BUSY);
    chk1("i_c2_ramREN", ramREN, 1'b1);
    chk("i_c2_ramaddr", ramaddr, 32'h40);
    chk1("i_c2_iwait", iwait, 1'b1);
    drive(0, 1, 0, 0, ACCESS);
    chk1("i_c3_iwait", iwait, 1'b0);
    chk("i_c3_iload", iload, 32'hDEAD_BEEF);
    drive(0, 1, 0, 0, ACCESS);
    chk1("i_c4_idle_iwait", iwait, 1'b1);
    chk1("i_c4_idle_ramREN", ramREN, 1'b0);
    chk("i_c4_iload", iload, '0);
    drive(0, 0, 0, 0, FREE);

    // Simultaneous icache read and dcache write: dcache first, write wins over read.
    daddr = 32'h80; dstore = 32'h1234; iaddr = 32'h44;
    drive(0, 1, 0, 1, BUSY);
    chk1("d_c1_dwait", dwait, 1'b1);
    chk1("d_c1_ramWEN", ramWEN, 1'b0);
    drive(0, 1, 1, 1, BUSY);
    chk1("d_c2_ramWEN", ramWEN, 1'b1);
    chk1("d_c2_ramREN", ramREN, 1'b0);
    chk("d_c2_ramstore", ramstore, 32'h1234);
    chk("d_c2_ramaddr", ramaddr, 32'h80);
    chk1("d_c2_iwait", iwait, 1'b1);
    drive(0, 1, 1, 1, ACCESS);
    chk1("d_c3_dwait", dwait, 1'b0);
    chk1("d_c3_iwait", iwait, 1'b1);
    drive(0, 1, 0, 0, BUSY);
    chk1("d_c4_iwait", iwait, 1'b1);
    chk1("d_c4_ramREN", ramREN, 1'b0);
    drive(0, 1, 0, 0, ACCESS);
    chk("d_c5_ramaddr", ramaddr, 32'h44);
    chk1("d_c5_iwait", iwait, 1'b0);
    chk("d_c5_iload", iload, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, FREE);

    // Back-to-back ties: D, I, D with round robin; D every time otherwise.
    daddr = 32'h100; iaddr = 32'h200;
    drive(0, 1, 1, 0, ACCESS);
    drive(0, 1, 1, 0, ACCESS);
    chk("tie1_ramaddr", ramaddr, 32'h100);
    drive(0, 1, 1, 0, ACCESS);
    drive(0, 1, 1, 0, ACCESS);
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie2_ramaddr", ramaddr, 32'h200);
    chk1("tie2_iwait", iwait, 1'b0);
`else
    chk("tie2_ramaddr", ramaddr, 32'h100);
    chk1("tie2_iwait", iwait, 1'b1);
`endif
    drive(0, 1, 1, 0, ACCESS);
    drive(0, 1, 1, 0, ACCESS);
    chk("tie3_ramaddr", ramaddr, 32'h100);
    drive(0, 0, 0, 0, FREE);

    // Reset mid-access, then a request dropped mid-service.
    daddr = 32'h300;
    drive(0, 0, 1, 0, BUSY);
    drive(0, 0, 1, 0, BUSY);
    chk1("rm_serve_ramREN", ramREN, 1'b1);
    drive(1, 0, 1, 0, ACCESS);
    chk1("rm_rst_ramREN", ramREN, 1'b0);
    chk("rm_rst_dload", dload, '0);
    chk("rm_rst_ramaddr", ramaddr, '0);
    chk1("rm_rst_dwait", dwait, 1'b1);
    drive(0, 0, 1, 0, BUSY);
    chk1("rm_after_ramREN", ramREN, 1'b0);
    chk1("rm_after_err", err, 1'b0);
    drive(0, 0, 1, 0, BUSY);
    chk1("drop_serve_ramREN", ramREN, 1'b1);
    drive(0, 0, 0, 0, BUSY);
    chk1("drop_ramREN", ramREN, 1'b0);
    chk1("drop_dwait", dwait, 1'b0);
    drive(0, 0, 1, 0, ACCESS);
    chk1("drop_idle_dwait", dwait, 1'b1);
    chk1("drop_idle_ramREN", ramREN, 1'b0);
    drive(0, 0, 0, 0, FREE);

    // Randomized traffic with sticky requests so timeouts and errors occur.
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK);
      #1;
      RST = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0) begin
        iREN = ($urandom_range(1) == 1);
        dREN = ($urandom_range(2) == 0);
        dWEN = ($urandom_range(2) == 0);
      end
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      rv = int'($urandom_range(99));
      if (rv < 3)       ramstate = ERROR;
      else if (rv < 75) ramstate = BUSY;
      else if (rv < 88) ramstate = ACCESS;
      else              ramstate = FREE;
    end

    // RAM error terminates the access and sets err the next cycle.
    ramload = 32'h5555_AAAA;
    drive(1, 0, 0, 0, FREE);
    drive(0, 0, 1, 0, BUSY);
    drive(0, 0, 1, 0, ERROR);
    chk1("er_dwait", dwait, 1'b0);
    chk("er_dload", dload, 32'h5555_AAAA);
    chk1("er_err_pre", err, 1'b0);
    drive(0, 0, 0, 0, FREE);
    chk1("er_err", err, 1'b1);

    // Timeout: RAM held BUSY for the whole service.
    daddr = 32'h500; ramload = 32'h0BAD_F00D;
    drive(1, 0, 0, 0, FREE);
    drive(0, 0, 1, 0, BUSY);
    chk1("tmo_idle_dwait", dwait, 1'b1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      drive(0, 0, 1, 0, BUSY);
      if (k < TIMEOUT) begin
        chk1("tmo_hold_dwait", dwait, 1'b1);
      end else begin
        chk1("tmo_dwait", dwait, 1'b0);
        chk("tmo_dload", dload, '0);
        chk1("tmo_err_pre", err, 1'b0);
      end
    end
    drive(0, 0, 1, 0, BUSY);
    chk1("tmo_err", err, 1'b1);
    chk1("tmo_idle_ramREN", ramREN, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 0, ACCESS);
      chk1("tmo_err_sticky", err, 1'b1);
    end
    drive(0, 0, 0, 0, FREE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
